multicycle_cu: RTL and testbench

- Multi-cycle control unit for the RV32I subset datapath: R, I-ALU, load word, store word and conditional branches.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Latches the instruction word and handshakes with unified memory via memreq/mem_ready.
- Drives the existing datapath control encodings, plus retire and trap reporting.

---
 rtl/multicycle_cu.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_cu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit for an RV32I subset datapath (R, I-ALU, lw, sw, branches).
// Walks FETCH/DECODE/EXEC/MEM/WB, counts retired instructions and latches trap causes.
module multicycle_cu #(
  parameter int CNT_W      = 32,
  parameter int WAIT_MAX   = 16,
  parameter int EXT_BRANCH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic [3:0]       status,
  output logic             memreq,
  output logic             memrw,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcsrc,
  output logic [3:0]       aluop,
  output logic [1:0]       immsel,
  output logic             alusrc,
  output logic             regrw,
  output logic             wb,
  output logic             retire,
  output logic [CNT_W-1:0] retired,
  output logic             trap,
  output logic             trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam int WAIT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t            state, state_next;
  logic [31:0]       ir;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired_q;
  logic              trap_q, cause_q;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_r, is_i, is_ld, is_st, is_br;
  logic       br_legal, br_taken, stall_limit;
  logic       c_memreq, c_memrw, c_irwrite, c_pcwrite, c_pcsrc;
  logic [3:0] c_aluop;
  logic [1:0] c_immsel;
  logic       c_alusrc, c_regrw, c_wb, c_retire;
  logic       enter_trap, cause_next;
  logic       unused_bits;

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign is_r   = (opcode == OP_R);
  assign is_i   = (opcode == OP_I);
  assign is_ld  = (opcode == OP_LW);
  assign is_st  = (opcode == OP_SW);
  assign is_br  = (opcode == OP_BR);
  assign unused_bits = ^{ir[31], ir[29:15], ir[11:7], status[3]};

  assign br_legal = (funct3 == 3'b000) || (funct3 == 3'b101) ||
                    ((EXT_BRANCH != 0) && ((funct3 == 3'b001) || (funct3 == 3'b100)));

  always_comb begin
    case (funct3)
      3'b000:  br_taken = status[2];
      3'b001:  br_taken = !status[2];
      3'b100:  br_taken = status[1] ^ status[0];
      3'b101:  br_taken = !(status[1] ^ status[0]);
      default: br_taken = 1'b0;
    endcase
  end

  // Handshake: memreq stays high until a cycle in which mem_ready=1; that cycle
  // completes the transfer. stall_limit marks the last stalled cycle allowed.
  assign stall_limit = (WAIT_MAX > 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_next = state;
    c_memreq   = 1'b0;
    c_memrw    = 1'b0;
    c_irwrite  = 1'b0;
    c_pcwrite  = 1'b0;
    c_pcsrc    = 1'b0;
    c_aluop    = 4'b0000;
    c_immsel   = 2'b00;
    c_alusrc   = 1'b0;
    c_regrw    = 1'b0;
    c_wb       = 1'b0;
    c_retire   = 1'b0;
    enter_trap = 1'b0;
    cause_next = 1'b0;
    case (state)
      S_FETCH: begin
        c_memreq = 1'b1;
        if (mem_ready) begin
          c_irwrite  = 1'b1;
          c_pcwrite  = 1'b1;
          state_next = S_DECODE;
        end else if (stall_limit) begin
          enter_trap = 1'b1;
          cause_next = 1'b1;
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        if (is_r || is_i || is_ld || is_st || (is_br && br_legal)) begin
          state_next = S_EXEC;
        end else begin
          enter_trap = 1'b1;
          state_next = S_TRAP;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          c_aluop    = {ir[30], funct3};
          state_next = S_WB;
        end else if (is_i) begin
          c_alusrc   = 1'b1;
          // Only the shift-right pair uses bit 30; for other I-ops it is immediate data.
          c_aluop    = (funct3 == 3'b101) ? {ir[30], funct3} : {1'b0, funct3};
          state_next = S_WB;
        end else if (is_ld) begin
          c_alusrc   = 1'b1;
          state_next = S_MEM;
        end else if (is_st) begin
          c_alusrc   = 1'b1;
          c_immsel   = 2'b01;
          state_next = S_MEM;
        end else begin
          c_immsel   = 2'b11;
          c_aluop    = 4'b1000;
          c_pcwrite  = br_taken;
          c_pcsrc    = br_taken;
          c_retire   = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_MEM: begin
        c_memreq = 1'b1;
        c_memrw  = is_st;
        if (mem_ready) begin
          c_retire   = is_st;
          state_next = is_st ? S_FETCH : S_WB;
        end else if (stall_limit) begin
          enter_trap = 1'b1;
          cause_next = 1'b1;
          state_next = S_TRAP;
        end
      end
      S_WB: begin
        c_regrw    = 1'b1;
        c_wb       = !is_ld;
        c_retire   = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      ir        <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (c_irwrite) ir <= instr;
      if (!c_memreq || mem_ready) wait_cnt <= '0;
      else                        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (c_retire) retired_q <= retired_q + CNT_W'(1);
      if (enter_trap) begin
        trap_q  <= 1'b1;
        cause_q <= cause_next;
      end
    end
  end

  // Every output is forced low while reset is held, whatever the current state.
  assign memreq     = c_memreq  & ~reset;
  assign memrw      = c_memrw   & ~reset;
  assign irwrite    = c_irwrite & ~reset;
  assign pcwrite    = c_pcwrite & ~reset;
  assign pcsrc      = c_pcsrc   & ~reset;
  assign aluop      = reset ? 4'b0000 : c_aluop;
  assign immsel     = reset ? 2'b00 : c_immsel;
  assign alusrc     = c_alusrc  & ~reset;
  assign regrw      = c_regrw   & ~reset;
  assign wb         = c_wb      & ~reset;
  assign retire     = c_retire  & ~reset;
  assign retired    = reset ? '0 : retired_q;
  assign trap       = trap_q    & ~reset;
  assign trap_cause = cause_q   & ~reset;

endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: table of single-instruction vectors checked through a
// retire scoreboard, plus sequences for traps, timeouts and reset mid-stall.
module tb_multicycle_cu;
  localparam int W = 17;
  localparam int NV = 21;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic [3:0]  status = 4'h0;

  logic        memreq, memrw, irwrite, pcwrite, pcsrc, alusrc, regrw, wb, retire, trap, trap_cause;
  logic [3:0]  aluop;
  logic [1:0]  immsel;
  logic [31:0] retired;
  logic        memreq_b, memrw_b, irwrite_b, pcwrite_b, pcsrc_b, alusrc_b, regrw_b, wb_b;
  logic        retire_b, trap_b, trap_cause_b;
  logic [3:0]  aluop_b;
  logic [1:0]  immsel_b;
  logic [31:0] retired_b;

  multicycle_cu dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .status(status),
    .memreq(memreq), .memrw(memrw), .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
    .aluop(aluop), .immsel(immsel), .alusrc(alusrc), .regrw(regrw), .wb(wb),
    .retire(retire), .retired(retired), .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_cu #(.CNT_W(32), .WAIT_MAX(4), .EXT_BRANCH(0)) dut_b (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .status(status),
    .memreq(memreq_b), .memrw(memrw_b), .irwrite(irwrite_b), .pcwrite(pcwrite_b), .pcsrc(pcsrc_b),
    .aluop(aluop_b), .immsel(immsel_b), .alusrc(alusrc_b), .regrw(regrw_b), .wb(wb_b),
    .retire(retire_b), .retired(retired_b), .trap(trap_b), .trap_cause(trap_cause_b)
  );

  logic [16:0] outs_a, outs_b;
  assign outs_a = {memreq, memrw, irwrite, pcwrite, pcsrc, aluop, immsel, alusrc, regrw, wb,
                   retire, trap, trap_cause};
  assign outs_b = {memreq_b, memrw_b, irwrite_b, pcwrite_b, pcsrc_b, aluop_b, immsel_b, alusrc_b,
                   regrw_b, wb_b, retire_b, trap_b, trap_cause_b};

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  status;
    int          fdel;
    int          ddel;
    logic [3:0]  aluop;
    logic [1:0]  immsel;
    logic        alusrc;
    logic        taken;
    logic        mreq;
    logic        mrw;
    logic        rg;
    logic        wbv;
    int          lat;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic [31:0] i, input logic [3:0] s, input int f, input int d,
                              input logic [3:0] op, input logic [1:0] im, input logic src,
                              input logic tk, input logic mreq, input logic mrw, input logic rg,
                              input logic wbv, input int lat);
    vec_t v;
    v.instr = i; v.status = s; v.fdel = f; v.ddel = d; v.aluop = op; v.immsel = im;
    v.alusrc = src; v.taken = tk; v.mreq = mreq; v.mrw = mrw; v.rg = rg; v.wbv = wbv; v.lat = lat;
    return v;
  endfunction

  // Signature of one retired instruction: EXEC-cycle controls, retire-cycle controls, latency.
  function automatic logic [W-1:0] sig_of(input vec_t v);
    return {v.aluop, v.immsel, v.alusrc, v.taken, v.taken, v.mreq, v.mrw, v.rg, v.wbv, 4'(v.lat)};
  endfunction

  // ---------------- memory responder ----------------
  logic stuck = 1'b1;
  int   fetch_delay = 0;
  int   data_delay = 0;
  int   req_cnt = 0;
  logic phase_data = 1'b0;

  always @(posedge clk) begin
    #2;
    if (reset || !memreq || stuck) begin
      mem_ready = 1'b0;
      req_cnt = 0;
    end else if (req_cnt >= (phase_data ? data_delay : fetch_delay)) begin
      mem_ready = 1'b1;
      req_cnt = 0;
    end else begin
      mem_ready = 1'b0;
      req_cnt++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int cyc = 0;
  int exec_idx = -1;
  int model_ret = 0;
  logic [8:0] exec_cap = '0;
  logic [W-1:0] got_sig;

  always @(negedge clk) begin
    if (reset) begin
      cyc = 0;
      exec_idx = -1;
      model_ret = 0;
      phase_data = 1'b0;
    end else begin
      cyc++;
      if (irwrite) begin
        exec_idx = cyc + 2;
        phase_data = 1'b1;
      end
      if (cyc == exec_idx) exec_cap = {aluop, immsel, alusrc, pcwrite, pcsrc};
      if (retire) begin
        got_sig = {exec_cap, memreq, memrw, regrw, wb, 4'(cyc)};
        check("sb_depth", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) check("retire_sig", 64'(got_sig), 64'(exp_q.pop_front()));
        check("retired_count", 64'(retired), 64'(model_ret));
        model_ret++;
        cyc = 0;
        exec_idx = -1;
        phase_data = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic stall_after);
    @(posedge clk); #1;
    stuck = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_outs", 64'(outs_a), 64'd0);
    check("reset_outs_b", 64'(outs_b), 64'd0);
    check("reset_retired", 64'(retired), 64'd0);
    check("reset_retired_b", 64'(retired_b), 64'd0);
    @(posedge clk); #1;
    stuck = stall_after;
    reset = 1'b0;
  endtask

  task automatic wait_retire(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!retire && k < budget);
    check("retire_seen", 64'(retire), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v);
    fetch_delay = v.fdel;
    data_delay = v.ddel;
    instr = v.instr;
    status = v.status;
    exp_q.push_back(sig_of(v));
    wait_retire(40);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk(32'h002081B3, 4'h0, 0, 0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4); // add
    vecs[1]  = mk(32'h402081B3, 4'h0, 0, 0, 4'b1000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4); // sub
    vecs[2]  = mk(32'h4020D193, 4'h0, 0, 0, 4'b1101, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4); // srai
    vecs[3]  = mk(32'hFFF08193, 4'h0, 0, 0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4); // addi -1
    vecs[4]  = mk(32'h00209193, 4'h0, 0, 0, 4'b0001, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4); // slli
    vecs[5]  = mk(32'h4020D1B3, 4'h0, 0, 0, 4'b1101, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4); // sra
    vecs[6]  = mk(32'h0020E1B3, 4'h0, 0, 0, 4'b0110, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4); // or
    vecs[7]  = mk(32'h0000A183, 4'h0, 0, 0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5); // lw
    vecs[8]  = mk(32'h0000A183, 4'h0, 0, 3, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8); // lw, 3 waits
    vecs[9]  = mk(32'h0020A023, 4'h0, 0, 0, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4); // sw
    vecs[10] = mk(32'h0020A023, 4'h0, 0, 2, 4'b0000, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6); // sw, 2 waits
    vecs[11] = mk(32'h00208463, 4'h4, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3); // beq Z
    vecs[12] = mk(32'h00208463, 4'h0, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3); // beq !Z
    vecs[13] = mk(32'h00209463, 4'h0, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3); // bne !Z
    vecs[14] = mk(32'h0020C463, 4'h3, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3); // blt N=V=1
    vecs[15] = mk(32'h0020D463, 4'h1, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3); // bge V only
    vecs[16] = mk(32'h0020D463, 4'h3, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3); // bge N=V
    vecs[17] = mk(32'h0020C463, 4'h2, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3); // blt N only
    vecs[18] = mk(32'h002081B3, 4'h0, 2, 0, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6); // add, slow fetch
    vecs[19] = mk(32'h00209463, 4'h4, 0, 0, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3); // bne Z
    vecs[20] = mk(32'hFFF08193, 4'h0, 1, 0, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5); // addi, slow fetch

    // Table phase on the default-parameter unit.
    do_reset(1'b0);
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);
    check("retired_after_table", 64'(retired), 64'(NV));

    // Reset clears the counter; memreq rises in the first cycle; illegal opcode traps and holds.
    do_reset(1'b0);
    instr = 32'h002081B3;
    status = 4'h0;
    fetch_delay = 0;
    data_delay = 0;
    exp_q.push_back(sig_of(vecs[0]));
    @(negedge clk);
    check("memreq_first_cycle", 64'({memreq, memrw}), 64'b10);
    wait_retire(40);
    instr = 32'h0000007F;
    @(negedge clk);
    @(negedge clk);
    check("no_early_trap", 64'(trap), 64'd0);
    @(negedge clk);
    check("illegal_trap", 64'({trap, trap_cause}), 64'b10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("trap_hold", {outs_a[16:2], trap, trap_cause, retired}, {15'b0, 1'b1, 1'b0, 32'd1});
    end

    // bne is legal on the default unit but traps the unit built without extended branches.
    do_reset(1'b0);
    instr = 32'h00209463;
    status = 4'h0;
    exp_q.push_back(sig_of(vecs[13]));
    wait_retire(40);
    stuck = 1'b1;
    check("extb_trap", 64'({trap_b, trap_cause_b}), 64'b10);
    check("extb_retired", 64'(retired_b), 64'd0);
    check("ext_no_trap", 64'({trap, retired}), {1'b0, 32'd1});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("extb_hold", 64'({outs_b[16:2], trap_b}), {15'b0, 1'b1});
    end

    // Fetch stuck: WAIT_MAX=4 unit traps after exactly 4 memreq cycles.
    do_reset(1'b1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("timeout_b", 64'({memreq_b, trap_b, trap_cause_b}), (i < 5) ? 64'b100 : 64'b011);
    end
    check("no_timeout_a", 64'({memreq, trap}), 64'b10);
    repeat (3) @(negedge clk);

    // Reset mid-stall, then the default unit times out after exactly 16 cycles.
    do_reset(1'b1);
    check("midstall_clear", 64'({trap, trap_b, retired}), 64'd0);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      check("timeout_a", 64'({memreq, trap, trap_cause}), (i < 17) ? 64'b100 : 64'b011);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
